// File: rtl/mac_pkg.sv
// Shared definitions for the MAC controller: state encoding, counter limits and
// the Moore output decode used by mac_ctrl_fsm.
package mac_pkg;

  localparam int CNT_W       = 4;
  localparam int N_TERMS_DEF = 8;
  localparam int WDOG_W      = 7;
  localparam int TIMEOUT_DEF = 64;

  localparam logic [CNT_W-1:0] COUNT_MAX = 4'd15;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_ACC   = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_OUT   = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_CLEAR = S_CLEAR,
    ST_LOAD  = S_LOAD,
    ST_MUL   = S_MUL,
    ST_ACC   = S_ACC,
    ST_CHECK = S_CHECK,
    ST_OUT   = S_OUT,
    ST_DONE  = S_DONE
  } state_e;

  typedef struct packed {
    logic in_ready;
    logic ld_m;
    logic ld_acc;
    logic ld_out;
    logic count_enb;
    logic count_reset;
    logic acc_clr;
    logic busy;
    logic done;
  } ctrl_out_t;

  // Output pattern of the state being entered; only one strobe group per state.
  function automatic ctrl_out_t decode_moore(input state_e st);
    ctrl_out_t o;
    o = '0;
    case (st)
      ST_CLEAR: begin
        o.count_reset = 1'b1;
        o.acc_clr     = 1'b1;
      end
      ST_LOAD:  o.in_ready = 1'b1;
      ST_MUL:   o.ld_m = 1'b1;
      ST_ACC: begin
        o.ld_acc    = 1'b1;
        o.count_enb = 1'b1;
      end
      ST_OUT:   o.ld_out = 1'b1;
      ST_DONE:  o.done = 1'b1;
      default:  o = '0;
    endcase
    o.busy = (st != ST_IDLE);
    return o;
  endfunction

endpackage

// File: rtl/mac_ctrl_watchdog.sv
// LOAD-state stall counter with terminal compare; only built when
// MAC_CTRL_TIMEOUT_EN is defined.
`ifdef MAC_CTRL_TIMEOUT_EN
module mac_ctrl_watchdog
  import mac_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_load,
  input  logic in_valid,
  output logic expire
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT_CYC - 1);

  logic [WDOG_W-1:0] stall_cnt_r;
  logic              stall_s;

  assign stall_s = in_load & ~in_valid;

  // Counts consecutive stalled LOAD cycles; any accepted pair or leaving LOAD restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {WDOG_W{1'b0}};
    end else if (!stall_s) begin
      stall_cnt_r <= {WDOG_W{1'b0}};
    end else begin
      stall_cnt_r <= stall_cnt_r + 7'd1;
    end
  end

  // Fires during the TIMEOUT_CYC-th stalled cycle so the FSM leaves on that edge.
  assign expire = stall_s & (stall_cnt_r == LIMIT);

endmodule
`endif

// File: rtl/mac_ctrl_fsm.sv
// Control FSM sequencing the MAC datapath strobes for one N_TERMS job.
// Optional LOAD stall timeout enabled with MAC_CTRL_TIMEOUT_EN.
module mac_ctrl_fsm
  import mac_pkg::*;
#(
  parameter int N_TERMS = N_TERMS_DEF
`ifdef MAC_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
`endif
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             CMP,
  input  logic [CNT_W-1:0] count_out,
  output logic             ld_a,
  output logic             ld_b,
  output logic             ld_m,
  output logic             ld_acc,
  output logic             ld_out,
  output logic             count_enb,
  output logic             count_reset,
  output logic             acc_clr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  if (N_TERMS < 1 || N_TERMS > int'(COUNT_MAX)) begin : g_bad_n_terms
    $error("mac_ctrl_fsm: N_TERMS out of range 1..15");
  end

  state_e    state_r;
  state_e    next_state_s;
  ctrl_out_t out_r;
  logic      err_r;
  logic      abort_s;
  logic      stall_expire_s;

`ifdef MAC_CTRL_TIMEOUT_EN
  mac_ctrl_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk_out),
    .rst_n   (rst),
    .in_load (state_r == ST_LOAD),
    .in_valid(in_valid),
    .expire  (stall_expire_s)
  );
`else
  assign stall_expire_s = 1'b0;
`endif

  // Next-state decode; abort_s flags the error exits that skip ld_out.
  always_comb begin
    next_state_s = state_r;
    abort_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_CLEAR;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CLEAR: next_state_s = ST_LOAD;
      ST_LOAD: begin
        if (in_valid) begin
          next_state_s = ST_MUL;
        end else if (stall_expire_s) begin
          next_state_s = ST_IDLE;
          abort_s      = 1'b1;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_MUL: next_state_s = ST_ACC;
      ST_ACC: next_state_s = ST_CHECK;
      ST_CHECK: begin
        // A counter at its ceiling without CMP means the threshold never matched.
        if (CMP) begin
          next_state_s = ST_OUT;
        end else if (count_out == COUNT_MAX) begin
          next_state_s = ST_IDLE;
          abort_s      = 1'b1;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_OUT:  next_state_s = ST_DONE;
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register with outputs registered from the state being entered.
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      out_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      out_r   <= decode_moore(next_state_s);
      err_r   <= abort_s;
    end
  end

  assign in_ready    = out_r.in_ready;
  assign ld_a        = out_r.in_ready & in_valid;
  assign ld_b        = out_r.in_ready & in_valid;
  assign ld_m        = out_r.ld_m;
  assign ld_acc      = out_r.ld_acc;
  assign ld_out      = out_r.ld_out;
  assign count_enb   = out_r.count_enb;
  assign count_reset = out_r.count_reset;
  assign acc_clr     = out_r.acc_clr;
  assign busy        = out_r.busy;
  assign done        = out_r.done;
  assign err         = err_r;

endmodule
